propose_scheduler: RTL and testbench

PROPOSE_SCHEDULER -- requirements
Module: propose_scheduler

---
 rtl/propose_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_propose_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/propose_scheduler.sv
// propose_scheduler: sweeps NUM_VARS variables num_sweeps times, launching one
//    proposal per variable and writing each accepted result to the assignment store.
// Latency: first proposal 1 cycle after an accepted start; at least 3 cycles per variable.
// Backpressure: waits in WAIT for in_propose_done. With PROPOSE_SCHED_TIMEOUT_EN defined,
//    a proposal is abandoned after TIMEOUT_CYCLES WAIT cycles and a sticky error is raised.
module propose_scheduler #(
   parameter int NUM_VARS       = 4,
   parameter int IDX_W          = 2,
   parameter int VAL_W          = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             in_clk,
   input  logic             in_reset,
   input  logic             in_start,
   input  logic [15:0]      in_num_sweeps,
   output logic             out_propose_enable,
   output logic [IDX_W-1:0] out_variable_index,
   input  logic             in_propose_done,
   input  logic [VAL_W-1:0] in_assignment_new,
   output logic             out_wr_en,
   output logic [IDX_W-1:0] out_wr_index,
   output logic [VAL_W-1:0] out_wr_data,
   output logic             out_busy,
   output logic             out_done,
   output logic [15:0]      out_sweep_count,
   output logic             out_timeout_err
);

   // Reject configurations where the index cannot address every variable.
   if (((2 ** IDX_W) < NUM_VARS) || (NUM_VARS < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_chk
      $error("propose_scheduler: invalid NUM_VARS/IDX_W/TIMEOUT_CYCLES combination");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [15:0]      sweep_cnt_q;
   logic [15:0]      target_q;
   logic [VAL_W-1:0] data_q;
   logic             en_q;
   logic             wr_en_q;
   logic             busy_q;
   logic             done_q;

   // Values a proposal exit (write or timeout) moves to.
   logic [IDX_W-1:0] idx_d;
   logic [15:0]      sweep_cnt_d;
   logic             run_end_d;

`ifdef PROPOSE_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] wait_cnt_q;
   logic          timeout_err_q;
`endif

   // Advance to the next variable; the last variable of a sweep wraps the index
   // and completes a sweep, which may finish the run.
   always_comb begin
      idx_d       = idx_q + 1'b1;
      sweep_cnt_d = sweep_cnt_q;
      if (idx_q == LAST_IDX) begin
         idx_d       = '0;
         sweep_cnt_d = sweep_cnt_q + 16'd1;
      end
      run_end_d = (sweep_cnt_d == target_q);
   end

   // Scheduler FSM: state, counters and all registered outputs.
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         sweep_cnt_q <= '0;
         target_q    <= '0;
         data_q      <= '0;
         en_q        <= 1'b0;
         wr_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef PROPOSE_SCHED_TIMEOUT_EN
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         // Strobes are single-cycle unless re-armed by a transition below.
         en_q    <= 1'b0;
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (in_start) begin
                  target_q    <= in_num_sweeps;
                  idx_q       <= '0;
                  sweep_cnt_q <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_ISSUE;
                  // A zero-sweep run passes through ISSUE with the enable
                  // suppressed and finishes on the following cycle.
                  en_q        <= (in_num_sweeps != 16'd0);
`ifdef PROPOSE_SCHED_TIMEOUT_EN
                  timeout_err_q <= 1'b0;
`endif
               end
            end

            ST_ISSUE: begin
               if (target_q == 16'd0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_WAIT;
`ifdef PROPOSE_SCHED_TIMEOUT_EN
                  wait_cnt_q <= '0;
`endif
               end
            end

            ST_WAIT: begin
               // A result in the final WAIT cycle takes priority over timeout.
               if (in_propose_done) begin
                  data_q  <= in_assignment_new;
                  wr_en_q <= 1'b1;
                  state_q <= ST_WRITE;
               end
`ifdef PROPOSE_SCHED_TIMEOUT_EN
               else if (wait_cnt_q == WAIT_LAST) begin
                  timeout_err_q <= 1'b1;
                  idx_q         <= idx_d;
                  sweep_cnt_q   <= sweep_cnt_d;
                  if (run_end_d) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_ISSUE;
                     en_q    <= 1'b1;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
`endif
            end

            ST_WRITE: begin
               idx_q       <= idx_d;
               sweep_cnt_q <= sweep_cnt_d;
               if (run_end_d) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_ISSUE;
                  en_q    <= 1'b1;
               end
            end

            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // The index register is only updated on proposal exit, so it is stable
   // from ISSUE through WRITE and doubles as the write address.
   assign out_propose_enable = en_q;
   assign out_variable_index = idx_q;
   assign out_wr_en          = wr_en_q;
   assign out_wr_index       = idx_q;
   assign out_wr_data        = data_q;
   assign out_busy           = busy_q;
   assign out_done           = done_q;
   assign out_sweep_count    = sweep_cnt_q;

`ifdef PROPOSE_SCHED_TIMEOUT_EN
   assign out_timeout_err = timeout_err_q;
`else
   assign out_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_propose_scheduler.sv
// Bench for propose_scheduler: directed runs checked cycle by cycle against a
// schedule model (enable/write/done cycle numbers derived from per-proposal delays),
// plus literal expectations for the documented scenarios.
module tb_propose_scheduler;

   localparam int NV = 4;
   localparam int IW = 2;
   localparam int VW = 8;
   localparam int TO = 16;
`ifdef PROPOSE_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          in_clk = 1'b0;
   logic          in_reset = 1'b1;
   logic          in_start = 1'b0;
   logic [15:0]   in_num_sweeps = '0;
   logic          in_propose_done = 1'b0;
   logic [VW-1:0] in_assignment_new = '0;
   logic          out_propose_enable;
   logic [IW-1:0] out_variable_index;
   logic          out_wr_en;
   logic [IW-1:0] out_wr_index;
   logic [VW-1:0] out_wr_data;
   logic          out_busy;
   logic          out_done;
   logic [15:0]   out_sweep_count;
   logic          out_timeout_err;

   propose_scheduler #(
      .NUM_VARS(NV), .IDX_W(IW), .VAL_W(VW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start),
      .in_num_sweeps(in_num_sweeps),
      .out_propose_enable(out_propose_enable), .out_variable_index(out_variable_index),
      .in_propose_done(in_propose_done), .in_assignment_new(in_assignment_new),
      .out_wr_en(out_wr_en), .out_wr_index(out_wr_index), .out_wr_data(out_wr_data),
      .out_busy(out_busy), .out_done(out_done), .out_sweep_count(out_sweep_count),
      .out_timeout_err(out_timeout_err)
   );

   always #5 in_clk = ~in_clk;

   int ntests = 0;
   int nfail  = 0;

   // Stimulus/model shared state (written only by the main thread).
   int dly_tab[64];      // cycles from enable to done; 0 = withhold
   int t_en[65];         // model: ISSUE cycle of proposal k (t_en[N] = done cycle)
   bit to_k[64];         // model: proposal k times out
   int nprop;
   int done_cyc;
   int cur_rel = 0;
   int run_id = 0;
   int stray_rel = -1;

   // Observations gathered by the compare step.
   int wr_seen, en_seen, done_at, first_wd, first_wi;

   function automatic logic [7:0] data_of(input int k);
      return 8'hA5 + 8'(k * 19);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fill(input int d);
      for (int i = 0; i < 64; i++) dly_tab[i] = d;
   endtask

   // Schedule model: each proposal costs ISSUE + WAIT(delay) + WRITE, or
   // ISSUE + TO WAIT cycles when it times out.
   task automatic build_model(input int sweeps);
      nprop = sweeps * NV;
      t_en[0] = 1;
      for (int k = 0; k < nprop; k++) begin
         to_k[k] = TO_EN && (dly_tab[k] == 0 || dly_tab[k] > TO);
         t_en[k+1] = t_en[k] + (to_k[k] ? 1 + TO : dly_tab[k] + 2);
      end
      done_cyc = (nprop == 0) ? 2 : t_en[nprop];
   endtask

   task automatic compare(input int r);
      bit exp_en, exp_wr, exp_err;
      int exp_idx, exp_sw, wi, wd;
      string s;
      exp_en = 0; exp_wr = 0; exp_err = 0; exp_idx = 0; exp_sw = 0; wi = 0; wd = 0;
      for (int k = 0; k < nprop; k++) begin
         if (t_en[k] == r) exp_en = 1;
         if (!to_k[k] && (t_en[k] + dly_tab[k] + 1 == r)) begin
            exp_wr = 1; wi = k % NV; wd = data_of(k);
         end
         if (t_en[k] <= r && r < t_en[k+1]) exp_idx = k % NV;
         if (t_en[k+1] <= r) begin
            if (k % NV == NV - 1) exp_sw++;
            if (to_k[k]) exp_err = 1;
         end
      end
      s = $sformatf("@%0d", r);
      chk({"enable", s}, out_propose_enable, exp_en);
      chk({"var_index", s}, out_variable_index, exp_idx);
      chk({"wr_en", s}, out_wr_en, exp_wr);
      chk({"busy", s}, out_busy, (r >= 1 && r <= done_cyc));
      chk({"done", s}, out_done, (r == done_cyc));
      chk({"sweep_count", s}, out_sweep_count, exp_sw);
      chk({"timeout_err", s}, out_timeout_err, exp_err);
      if (exp_wr) begin
         chk({"wr_index", s}, out_wr_index, wi);
         chk({"wr_data", s}, out_wr_data, wd);
      end
      if (out_propose_enable) en_seen++;
      if (out_done) done_at = r;
      if (out_wr_en) begin
         if (wr_seen == 0) begin
            first_wd = out_wr_data;
            first_wi = out_wr_index;
         end
         wr_seen++;
      end
   endtask

   // One run; poke=1 adds a start pulse with a new sweep count mid-run and a
   // stray done during the ISSUE cycle of proposal 3.
   task automatic do_run(input int sweeps, input bit poke);
      build_model(sweeps);
      wr_seen = 0; en_seen = 0; done_at = -1; first_wd = -1; first_wi = -1;
      stray_rel = poke ? t_en[3] : -1;
      @(posedge in_clk); #1;
      run_id++;
      cur_rel = 0;
      in_num_sweeps = 16'(sweeps);
      in_start = 1'b1;
      for (int r = 1; r <= done_cyc + 2; r++) begin
         @(posedge in_clk); #1;
         cur_rel = r;
         in_start = poke && (r == 14);
         if (poke && r == 14) in_num_sweeps = 16'd5;
         @(negedge in_clk);
         compare(r);
      end
      in_start = 1'b0;
      stray_rel = -1;
      chk("done_cycle_vs_model", done_at, done_cyc);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_enable"}, out_propose_enable, 0);
      chk({tag, "_var_index"}, out_variable_index, 0);
      chk({tag, "_wr_en"}, out_wr_en, 0);
      chk({tag, "_wr_index"}, out_wr_index, 0);
      chk({tag, "_wr_data"}, out_wr_data, 0);
      chk({tag, "_busy"}, out_busy, 0);
      chk({tag, "_done"}, out_done, 0);
      chk({tag, "_sweep_count"}, out_sweep_count, 0);
      chk({tag, "_timeout_err"}, out_timeout_err, 0);
   endtask

   // Proposer responder: answers each enable after dly_tab[ordinal] cycles,
   // holding data only in the done cycle.
   initial begin
      int cnt, ord, cur_ord, seen_run;
      cnt = 0; ord = 0; cur_ord = 0; seen_run = 0;
      forever begin
         @(posedge in_clk); #2;
         if (run_id != seen_run) begin
            seen_run = run_id; ord = 0; cnt = 0;
         end
         in_propose_done = 1'b0;
         in_assignment_new = '0;
         if (in_reset) begin
            cnt = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               in_propose_done = 1'b1;
               in_assignment_new = data_of(cur_ord);
            end
         end
         if (!in_propose_done && stray_rel >= 0 && cur_rel == stray_rel) begin
            in_propose_done = 1'b1;
            in_assignment_new = 8'hFF;
         end
         if (out_propose_enable && !in_reset) begin
            cur_ord = ord;
            cnt = dly_tab[ord];
            ord++;
         end
      end
   end

   initial begin
      fill(2);
      // Reset state.
      in_reset = 1'b1;
      repeat (3) @(posedge in_clk);
      @(negedge in_clk);
      chk_all_zero("reset");
      @(posedge in_clk); #1;
      in_reset = 1'b0;

      // Basic run: 2 sweeps, done 2 cycles after each enable.
      fill(2);
      do_run(2, 1'b0);
      chk("basic_done_cycle", done_at, 33);
      chk("basic_writes", wr_seen, 8);
      chk("basic_first_wr_data", first_wd, 8'hA5);
      chk("basic_sweep_count", out_sweep_count, 2);

      // Zero sweeps.
      do_run(0, 1'b0);
      chk("zero_done_cycle", done_at, 2);
      chk("zero_enables", en_seen, 0);
      chk("zero_writes", wr_seen, 0);

      // Busy start and stray done.
      fill(2);
      do_run(2, 1'b1);
      chk("busy_writes", wr_seen, 8);
      chk("busy_done_cycle", done_at, 33);
      chk("busy_sweep_count", out_sweep_count, 2);

      // Reset during WAIT of index 2 (ISSUE at 9, WAIT at 10..11).
      fill(2);
      @(posedge in_clk); #1;
      run_id++;
      cur_rel = 0;
      in_num_sweeps = 16'd1;
      in_start = 1'b1;
      for (int r = 1; r <= 10; r++) begin
         @(posedge in_clk); #1;
         cur_rel = r;
         in_start = 1'b0;
         if (r == 10) in_reset = 1'b1;
         @(negedge in_clk);
      end
      chk("rst_pre_busy", out_busy, 1);
      chk("rst_pre_index", out_variable_index, 2);
      @(posedge in_clk); #1;
      in_reset = 1'b0;
      @(negedge in_clk);
      chk_all_zero("midrun_reset");
      fill(1);
      do_run(1, 1'b0);
      chk("restart_done_cycle", done_at, 13);
      chk("restart_first_wr_index", first_wi, 0);
      chk("restart_writes", wr_seen, 4);

`ifdef PROPOSE_SCHED_TIMEOUT_EN
      // Done withheld for index 1: proposal abandoned after 16 WAIT cycles.
      fill(2);
      dly_tab[1] = 0;
      do_run(1, 1'b0);
      chk("to_done_cycle", done_at, 30);
      chk("to_writes", wr_seen, 3);
      chk("to_err", out_timeout_err, 1);
      // Done in the 16th WAIT cycle wins over timeout.
      fill(2);
      dly_tab[0] = 16;
      do_run(1, 1'b0);
      chk("to_edge_done_cycle", done_at, 31);
      chk("to_edge_writes", wr_seen, 4);
      chk("to_edge_err", out_timeout_err, 0);
`else
      // Without timeout support a long wait still completes normally.
      fill(2);
      dly_tab[1] = 20;
      do_run(1, 1'b0);
      chk("longwait_done_cycle", done_at, 35);
      chk("longwait_writes", wr_seen, 4);
      chk("longwait_err", out_timeout_err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
